// File: rtl/ulss_packet_store_if.sv
// Write-side word stream, read grant and packet-out stream of the packet store.
// Master is the producer/limiter side, slave is the store.
interface ulss_packet_store_if #(
  parameter int DATA_W = 64
);
  logic              wr_valid;
  logic              wr_sop;
  logic              wr_eop;
  logic [DATA_W-1:0] wr_data;
  logic              pck_rd_en_grnt;
  logic              pck_str_empty;
  logic              pck_valid;
  logic              pck_sop;
  logic              pck_eop;
  logic [DATA_W-1:0] pck_data;
  logic [15:0]       drop_cnt;

  modport master (
    output wr_valid, wr_sop, wr_eop, wr_data, pck_rd_en_grnt,
    input  pck_str_empty, pck_valid, pck_sop, pck_eop, pck_data, drop_cnt
  );

  modport slave (
    input  wr_valid, wr_sop, wr_eop, wr_data, pck_rd_en_grnt,
    output pck_str_empty, pck_valid, pck_sop, pck_eop, pck_data, drop_cnt
  );
endinterface

// File: rtl/ulss_packet_store.sv
// Store-and-forward packet buffer: packets become readable only once their eop
// is written; a grant streams one whole packet out back-to-back.
module ulss_packet_store #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32
) (
  input  logic                 rate_limiter_16to4_clk,
  input  logic                 rate_limiter_16to4_rst,
  input  logic                 rate_limiter_16to4_sw_rst,
  ulss_packet_store_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wstate_t;
  typedef enum logic       {R_IDLE, R_READ}         rstate_t;

  // Each entry holds {sop, eop, data}
  logic [DATA_W+1:0] mem [DEPTH];

  wstate_t           wstate_q, wstate_d;
  rstate_t           rstate_q, rstate_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              pck_valid_q, pck_valid_d;
  logic              pck_sop_q, pck_sop_d;
  logic              pck_eop_q, pck_eop_d;
  logic [DATA_W-1:0] pck_data_q, pck_data_d;

  logic              start, take, commit, rd_en, rd_last;
  logic [1:0]        drop_add;
  logic [PW-1:0]     base, occ;
  logic [16:0]       drop_sum;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W+1:0] rd_word;

  always_ff @(posedge rate_limiter_16to4_clk or posedge rate_limiter_16to4_rst) begin
    if (rate_limiter_16to4_rst) begin
      wstate_q     <= W_IDLE;
      rstate_q     <= R_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      pck_valid_q  <= 1'b0;
      pck_sop_q    <= 1'b0;
      pck_eop_q    <= 1'b0;
      pck_data_q   <= '0;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      pck_valid_q  <= pck_valid_d;
      pck_sop_q    <= pck_sop_d;
      pck_eop_q    <= pck_eop_d;
      pck_data_q   <= pck_data_d;
    end
  end

  always_ff @(posedge rate_limiter_16to4_clk) begin
    if (mem_we) mem[mem_waddr] <= {bus.wr_sop, bus.wr_eop, bus.wr_data};
  end

  // Write side: a new sop always restarts at commit_ptr, abandoning any partial packet
  always_comb begin
    wstate_d     = wstate_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    start        = 1'b0;
    take         = 1'b0;
    commit       = 1'b0;
    drop_add     = 2'd0;
    mem_we       = 1'b0;
    if (bus.wr_valid) begin
      case (wstate_q)
        W_IDLE: start = bus.wr_sop;
        W_RECV: begin
          if (bus.wr_sop) begin
            drop_add = 2'd1;
            start    = 1'b1;
          end else begin
            take = 1'b1;
          end
        end
        W_DROP: begin
          if (bus.wr_sop)      start    = 1'b1;
          else if (bus.wr_eop) wstate_d = W_IDLE;
        end
        default: wstate_d = W_IDLE;
      endcase
    end
    base      = start ? commit_ptr_q : wr_ptr_q;
    occ       = base - rd_ptr_q;
    mem_waddr = base[AW-1:0];
    if (start || take) begin
      if (occ == PW'(DEPTH)) begin
        drop_add = drop_add + 2'd1;
        wr_ptr_d = commit_ptr_q;
        wstate_d = bus.wr_eop ? W_IDLE : W_DROP;
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = base + 1'b1;
        if (bus.wr_eop) begin
          commit       = 1'b1;
          commit_ptr_d = base + 1'b1;
          wstate_d     = W_IDLE;
        end else begin
          wstate_d = W_RECV;
        end
      end
    end
    drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_add);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    if (rate_limiter_16to4_sw_rst) begin
      wstate_d     = W_IDLE;
      wr_ptr_d     = '0;
      commit_ptr_d = '0;
      drop_cnt_d   = '0;
      mem_we       = 1'b0;
      commit       = 1'b0;
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    rd_ptr_d = rd_ptr_q;
    rd_word  = mem[rd_ptr_q[AW-1:0]];
    rd_en    = ((rstate_q == R_IDLE) && bus.pck_rd_en_grnt && (pkt_cnt_q != '0)) ||
               ((rstate_q == R_READ) && (rd_ptr_q != commit_ptr_q));
    rd_last  = rd_en && rd_word[DATA_W];
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rstate_d = rd_last ? R_IDLE : R_READ;
    end
    case ({commit, rd_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    pck_valid_d = rd_en;
    pck_sop_d   = rd_en && rd_word[DATA_W+1];
    pck_eop_d   = rd_last;
    pck_data_d  = rd_en ? rd_word[DATA_W-1:0] : pck_data_q;
    if (rate_limiter_16to4_sw_rst) begin
      rstate_d    = R_IDLE;
      rd_ptr_d    = '0;
      pkt_cnt_d   = '0;
      pck_valid_d = 1'b0;
      pck_sop_d   = 1'b0;
      pck_eop_d   = 1'b0;
      pck_data_d  = '0;
    end
  end

  assign bus.pck_str_empty = (pkt_cnt_q == '0);
  assign bus.pck_valid     = pck_valid_q;
  assign bus.pck_sop       = pck_sop_q;
  assign bus.pck_eop       = pck_eop_q;
  assign bus.pck_data      = pck_data_q;
  assign bus.drop_cnt      = drop_cnt_q;
endmodule
